// File: rtl/pipe_stage_skid.sv
// ============================================================================
// Module   : pipe_stage_skid
// Function : Valid/ready pipeline register with a main and a skid entry.
//            It forces a NOP control bundle whenever the output is idle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_skid #(
  parameter int                DATA_W   = 160,
  parameter int                CTRL_W   = 24,
  parameter logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        level
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [1:0]        r_level;

  logic              w_fire_in;
  logic              w_fire_out;

  assign w_fire_in  = in_valid & r_in_ready;
  assign w_fire_out = r_out_valid & out_ready;

  // The main control register holds CTRL_NOP whenever the main entry is
  // empty, so out_ctrl is a pure register output with no gating mux.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= CTRL_NOP;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_level     <= 2'd0;
    end else if (flush) begin
      // A beat offered in this cycle is dropped; out_data keeps its value.
      r_state     <= ST_EMPTY;
      r_main_ctrl <= CTRL_NOP;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_level     <= 2'd0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_fire_in) begin
            r_state     <= ST_ONE;
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
            r_out_valid <= 1'b1;
            r_level     <= 2'd1;
          end
        end
        ST_ONE: begin
          if (w_fire_in && w_fire_out) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end else if (w_fire_in) begin
            // Downstream stalled: park the new beat behind the main entry.
            r_state     <= ST_TWO;
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
            r_in_ready  <= 1'b0;
            r_level     <= 2'd2;
          end else if (w_fire_out) begin
            r_state     <= ST_EMPTY;
            r_main_ctrl <= CTRL_NOP;
            r_out_valid <= 1'b0;
            r_level     <= 2'd0;
          end
        end
        ST_TWO: begin
          if (w_fire_out) begin
            r_state     <= ST_ONE;
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
            r_in_ready  <= 1'b1;
            r_level     <= 2'd1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_main_ctrl <= CTRL_NOP;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_level     <= 2'd0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main_data;
  assign out_ctrl  = r_main_ctrl;
  assign level     = r_level;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus a random run against
// a queue-based model of a two-deep FIFO stage.
`default_nettype none

module tb_pipe_stage_skid;

  localparam int          DW  = 16;
  localparam int          CW  = 8;
  localparam logic [7:0]  NOP = 8'h05;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    level;

  int checks;
  int errors;

  // Model: the stage is a FIFO of at most two beats, each {data, ctrl}.
  logic [DW+CW-1:0] mq[$];

  pipe_stage_skid #(
    .DATA_W   (DW),
    .CTRL_W   (CW),
    .CTRL_NOP (NOP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; the model applies the FIFO rules to the inputs present
  // before the edge, then outputs are observed 1 time unit after the edge.
  task automatic advance();
    bit fi;
    bit fo;
    fi = in_valid && (mq.size() < 2);
    fo = out_ready && (mq.size() > 0);
    @(posedge clk);
    if (reset) mq.delete();
    else if (flush) mq.delete();
    else begin
      if (fo) void'(mq.pop_front());
      if (fi) mq.push_back({in_data, in_ctrl});
    end
    #1;
  endtask

  task automatic idle_inputs();
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_ctrl  = '0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    advance();
    advance();
    #2 reset = 1'b1;
    #1;
    mq.delete();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (out_ctrl !== NOP) begin errors++; $display("FAIL reset_out_ctrl got %h want %h", out_ctrl, NOP); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      in_ctrl  = CW'(8'h10 + i);
      advance();
      checks++; if (out_valid !== 1'b1 || out_data !== DW'(i)) begin errors++; $display("FAIL stream_data beat %0d got v=%0b d=%h want v=1 d=%h", i, out_valid, out_data, i); end
      checks++; if (out_ctrl !== CW'(8'h10 + i)) begin errors++; $display("FAIL stream_ctrl beat %0d got %h want %h", i, out_ctrl, 8'h10 + i); end
      checks++; if (level !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL stream_level beat %0d got lvl=%0d rdy=%0b want lvl=1 rdy=1", i, level, in_ready); end
    end
    in_valid = 1'b0;
    advance();
    checks++; if (level !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== NOP) begin errors++; $display("FAIL stream_drain got lvl=%0d v=%0b c=%h want 0 0 %h", level, out_valid, out_ctrl, NOP); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 16'h000A; in_ctrl = 8'hA0; advance();
    in_data = 16'h000B; in_ctrl = 8'hB0; advance();
    checks++; if (level !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got lvl=%0d rdy=%0b want lvl=2 rdy=0", level, in_ready); end
    in_data = 16'h000C; in_ctrl = 8'hC0; advance();
    checks++; if (level !== 2'd2 || out_data !== 16'h000A) begin errors++; $display("FAIL bp_stall got lvl=%0d d=%h want lvl=2 d=000a", level, out_data); end
    out_ready = 1'b1;
    advance();
    checks++; if (out_data !== 16'h000B || out_ctrl !== 8'hB0 || level !== 2'd1) begin errors++; $display("FAIL bp_second got d=%h c=%h lvl=%0d want 000b b0 1", out_data, out_ctrl, level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise got %0b want 1", in_ready); end
    advance();
    checks++; if (out_data !== 16'h000C || out_ctrl !== 8'hC0 || level !== 2'd1) begin errors++; $display("FAIL bp_third got d=%h c=%h lvl=%0d want 000c c0 1", out_data, out_ctrl, level); end
    in_valid = 1'b0;
    advance();
    checks++; if (level !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got lvl=%0d v=%0b want 0 0", level, out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 16'h1111; in_ctrl = 8'h11; advance();
    in_data = 16'h2222; in_ctrl = 8'h22; advance();
    in_data = 16'h00DD; in_ctrl = 8'hDD; flush = 1'b1;
    advance();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (level !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got lvl=%0d v=%0b want 0 0", level, out_valid); end
    checks++; if (out_ctrl !== NOP || in_ready !== 1'b1) begin errors++; $display("FAIL flush_outs got c=%h rdy=%0b want %h 1", out_ctrl, in_ready, NOP); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      advance();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost cycle %0d got v=%0b d=%h want v=0", i, out_valid, out_data); end
    end
  endtask

  task automatic test_nop();
    idle_inputs();
    advance();
    checks++; if (out_ctrl !== NOP) begin errors++; $display("FAIL nop_empty got %h want %h", out_ctrl, NOP); end
    in_valid = 1'b1; in_data = 16'h0F0F; in_ctrl = 8'hFF;
    advance();
    in_valid = 1'b0;
    checks++; if (out_ctrl !== 8'hFF) begin errors++; $display("FAIL nop_loaded got %h want ff", out_ctrl); end
    out_ready = 1'b1;
    advance();
    checks++; if (out_ctrl !== NOP) begin errors++; $display("FAIL nop_drained got %h want %h", out_ctrl, NOP); end
  endtask

  task automatic test_async_reset_two();
    idle_inputs();
    in_valid = 1'b1;
    in_data = 16'h3333; in_ctrl = 8'h33; advance();
    in_data = 16'h4444; in_ctrl = 8'h44; advance();
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    mq.delete();
    checks++; if (out_valid !== 1'b0 || level !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL areset_state got v=%0b lvl=%0d rdy=%0b want 0 0 1", out_valid, level, in_ready); end
    checks++; if (out_ctrl !== NOP || out_data !== '0) begin errors++; $display("FAIL areset_data got c=%h d=%h want %h 0", out_ctrl, out_data, NOP); end
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b1; in_data = 16'h5555; in_ctrl = 8'h55;
    advance();
    in_valid = 1'b0;
    checks++; if (level !== 2'd1 || out_data !== 16'h5555 || out_ctrl !== 8'h55) begin errors++; $display("FAIL areset_first got lvl=%0d d=%h c=%h want 1 5555 55", level, out_data, out_ctrl); end
    advance();
    checks++; if (level !== 2'd1 || out_data !== 16'h5555) begin errors++; $display("FAIL areset_alone got lvl=%0d d=%h want 1 5555", level, out_data); end
    out_ready = 1'b1;
    advance();
  endtask

  task automatic test_random();
    logic [CW-1:0] exp_ctrl;
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = DW'($urandom);
      in_ctrl   = CW'($urandom);
      advance();
      exp_ctrl = (mq.size() > 0) ? mq[0][CW-1:0] : NOP;
      checks++; if (level !== 2'(mq.size()) || in_ready !== (mq.size() < 2)) begin errors++; $display("FAIL rand_level cyc %0d got lvl=%0d rdy=%0b want lvl=%0d", n, level, in_ready, mq.size()); end
      checks++; if (out_valid !== (mq.size() > 0) || out_ctrl !== exp_ctrl) begin errors++; $display("FAIL rand_ctrl cyc %0d got v=%0b c=%h want c=%h", n, out_valid, out_ctrl, exp_ctrl); end
      if (mq.size() > 0) begin
        checks++; if (out_data !== mq[0][DW+CW-1:CW]) begin errors++; $display("FAIL rand_data cyc %0d got %h want %h", n, out_data, mq[0][DW+CW-1:CW]); end
      end
    end
    idle_inputs();
    advance();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    idle_inputs();
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_nop();
    test_async_reset_two();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
